fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end: owns the architectural fetch PC, issues instruction-bus requests, and presents one fetched instruction at a time to the IF/ID pipeline register as `fetch_data_t`. It sits between the instruction bus and the fetch pipeline register. It drives that register's `dataF` and `stallI` inputs, and accepts a branch/jump redirect from execute.

## Interface
- `PC_RESET`, default 64'h8000_0000: PC fetched first after reset.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ireq` out `ibus_req_t`: `valid` (u1), `addr` (u64) instruction request.
- `iresp` in `ibus_resp_t`: `addr_ok` (u1), `data_ok` (u1), `data` (u32).
- `dataF` out `fetch_data_t`: `pc` (u64), `raw_instr` (u32) of the buffered instruction.
- `validF` out 1: `dataF` holds a live instruction.
- `stallI` out 1: no live instruction available; equals `~validF`.
- `hold` in 1: downstream cannot accept `dataF` this cycle.
- `redirect` in 1: control-flow change; discard in-flight and buffered work.
- `redirect_pc` in 64: new fetch PC; bits [1:0] forced to 0 on capture.

## Operation
- State machine with states REQ, FLUSH and HOLD, plus registers `pc` (u64), `ibuf` (u32) and `pend_pc` (u64).
- Reset: state REQ, `pc` = `PC_RESET`, `ibuf` = 0, `pend_pc` = 0.
- Reset outputs, first cycle after reset: `ireq.valid`=1, `ireq.addr`=`PC_RESET`, `validF`=0, `stallI`=1, `dataF`='0.
- REQ:
  - `ireq.valid`=1 and `ireq.addr`=`pc`.
  - `data_ok`=1 and `redirect`=0: `ibuf` <= `data`, go to HOLD.
  - `data_ok`=1 and `redirect`=1: drop `data`, `pc` <= `redirect_pc`, stay in REQ.
  - `data_ok`=0 and `redirect`=1: `pend_pc` <= `redirect_pc`, go to FLUSH.
  - Otherwise stay in REQ.
- FLUSH:
  - `ireq` is held identical to the abandoned request; the bus rule is that a request stays stable until `data_ok`.
  - `redirect`=1 overwrites `pend_pc`.
  - On `data_ok`, data is dropped and `pc` <= `redirect` ? `redirect_pc` : `pend_pc`; go to REQ.
- HOLD:
  - `ireq.valid`=0, `validF`=1, `dataF`={`pc`, `ibuf`}.
  - `redirect`=1 takes priority over `hold`: `pc` <= `redirect_pc`, go to REQ.
  - Otherwise, if `hold`=0 the instruction is consumed: `pc` <= `pc`+4 (64-bit wrap), go to REQ.
  - `hold`=1 keeps `dataF` stable.
- `addr_ok` is ignored; completion is signalled only by `data_ok`.
- `data_ok` outside REQ/FLUSH is ignored.
- `dataF` is '0 whenever `validF`=0.
- All outputs are decoded from registered state. There is no combinational path from `iresp`, `hold` or `redirect` to `ireq`, `dataF` or `validF`.

## Timing
- Fetch latency: the request issues in the first REQ cycle. With `data_ok` in cycle N, `validF`=1 in cycle N+1.
- Peak throughput is 1 instruction per 2 cycles with a zero-wait bus: REQ, then HOLD.
- A redirect takes effect on the next cycle. The first request to the new PC issues in the cycle after redirect when the bus is idle, or in the cycle after the abandoned `data_ok` when in FLUSH.
- Reset asserted mid-transaction returns to REQ at `PC_RESET` next cycle. The bus is reset in the same cycle, so no drain is required.

## Structure
- `ibus_req_t`, `ibus_resp_t`, `fetch_data_t` and `u1`/`u32`/`u64` live in `common`/`pipes`.
- The state enum `fetch_state_t` is local to the module.
- `PC_RESET` is also exported as a constant from `common`.
- No sub-module is needed; a single always_ff for the FSM and registers plus a single always_comb for outputs is sufficient.

## Test plan
- **Reset then zero-wait bus:** `data_ok`=1 every request, `hold`=0 → `ireq.addr` sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; `validF` toggles 0,1,0,1; `raw_instr` matches the bus data.
- **Wait states:** `data_ok` delayed 3 cycles → `ireq` is stable for all 4 cycles, `stallI`=1 throughout, and `validF` rises exactly one cycle after `data_ok`.
- **Downstream hold:** in HOLD, `hold`=1 for 4 cycles → `dataF` unchanged, `ireq.valid`=0, `pc` not incremented; release → next request at `pc`+4.
- **Redirect during outstanding request:** redirect to 0x8000_0100 while waiting, `data_ok` 2 cycles later → the returned data is never presented, and the next request goes to 0x8000_0100.
- **Redirect with `data_ok` same cycle, and a double redirect in FLUSH:** the last `redirect_pc` wins (e.g. 0x200, then 0x300 → fetch 0x300); redirect_pc 0x8000_0102 → fetch 0x8000_0100.
- **Reset mid-FLUSH and redirect over hold:** → state REQ at `PC_RESET`; in HOLD with `hold`=1, redirect discards the buffered instruction and `validF`=0 next cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch front end.
//   u1/u32/u64    : scalar aliases
//   ibus_req_t    : instruction-bus request  {valid, addr}
//   ibus_resp_t   : instruction-bus response {addr_ok, data_ok, data}
//   fetch_data_t  : payload handed to the IF/ID register {pc, raw_instr}
//   PC_RESET      : architectural reset PC
//   align_pc()    : clears the low two bits of a fetch address
package fetch_unit_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u64 PC_RESET = 64'h8000_0000;

    typedef struct packed {
        u1  valid;
        u64 addr;
    } ibus_req_t;

    typedef struct packed {
        u1  addr_ok;
        u1  data_ok;
        u32 data;
    } ibus_resp_t;

    typedef struct packed {
        u64 pc;
        u32 raw_instr;
    } fetch_data_t;

    function automatic u64 align_pc(input u64 a);
        return {a[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues instruction-bus requests and presents
// one fetched instruction at a time to the IF/ID register.
//   clk, reset    : clock, synchronous active-high reset
//   ireq          : instruction-bus request (held stable until data_ok)
//   iresp         : instruction-bus response; only data_ok/data are used
//   dataF, validF : buffered instruction and its valid flag
//   stallI        : ~validF
//   hold          : downstream cannot take dataF this cycle
//   redirect(_pc) : control-flow change from execute
// All outputs decode from registered state only.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter u64 PC_RESET = fetch_unit_pkg::PC_RESET
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    output fetch_data_t dataF,
    output logic        validF,
    output logic        stallI,
    input  logic        hold,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    fetch_state_t r_state;
    u64           r_pc;
    u32           r_ibuf;
    u64           r_pend_pc;

    u64 w_redir_pc;
    assign w_redir_pc = align_pc(redirect_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= REQ;
            r_pc      <= PC_RESET;
            r_ibuf    <= '0;
            r_pend_pc <= '0;
        end else begin
            case (r_state)
                REQ: begin
                    if (iresp.data_ok && !redirect) begin
                        r_ibuf  <= iresp.data;
                        r_state <= HOLD;
                    end else if (iresp.data_ok && redirect) begin
                        // Response already back, so the bus is free: go straight to the new PC.
                        r_pc <= w_redir_pc;
                    end else if (redirect) begin
                        // Request still outstanding: park the target until it drains.
                        r_pend_pc <= w_redir_pc;
                        r_state   <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (iresp.data_ok) begin
                        r_pc    <= redirect ? w_redir_pc : r_pend_pc;
                        r_state <= REQ;
                    end else if (redirect) begin
                        r_pend_pc <= w_redir_pc;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        r_pc    <= w_redir_pc;
                        r_state <= REQ;
                    end else if (!hold) begin
                        r_pc    <= r_pc + 64'd4;
                        r_state <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

    // FLUSH keeps presenting the abandoned request, since r_pc is untouched there.
    always_comb begin
        ireq       = '0;
        dataF      = '0;
        validF     = 1'b0;
        ireq.valid = (r_state == REQ) || (r_state == FLUSH);
        ireq.addr  = ireq.valid ? r_pc : 64'd0;
        if (r_state == HOLD) begin
            validF          = 1'b1;
            dataF.pc        = r_pc;
            dataF.raw_instr = r_ibuf;
        end
        stallI = ~validF;
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    fetch_data_t dataF;
    logic        validF, stallI, hold, redirect;
    logic [63:0] redirect_pc;

    int n_chk = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .dataF(dataF), .validF(validF), .stallI(stallI),
        .hold(hold), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and sample #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic dok, input logic [31:0] d, input logic h,
                       input logic rd, input logic [63:0] rpc);
        iresp.addr_ok = dok;
        iresp.data_ok = dok;
        iresp.data    = d;
        hold          = h;
        redirect      = rd;
        redirect_pc   = rpc;
    endtask

    task automatic chk_req(input string tag, input logic [63:0] addr);
        chk({tag, ".v"},  ireq.valid, 1'b1);
        chk({tag, ".a"},  ireq.addr, addr);
        chk({tag, ".vF"}, validF, 1'b0);
        chk({tag, ".sI"}, stallI, 1'b1);
        chk({tag, ".dF"}, dataF, '0);
    endtask

    task automatic chk_hold(input string tag, input logic [63:0] pc, input logic [31:0] ins);
        chk({tag, ".v"},  ireq.valid, 1'b0);
        chk({tag, ".vF"}, validF, 1'b1);
        chk({tag, ".sI"}, stallI, 1'b0);
        chk({tag, ".pc"}, dataF.pc, pc);
        chk({tag, ".ri"}, dataF.raw_instr, ins);
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        chk_req("rst", 64'h8000_0000);

        // zero-wait bus
        drv(1, 32'h1111_1111, 0, 0, 0); tick();
        chk_hold("zw0", 64'h8000_0000, 32'h1111_1111);
        drv(0, 0, 0, 0, 0); tick();
        chk_req("zw1", 64'h8000_0004);
        drv(1, 32'h2222_2222, 0, 0, 0); tick();
        chk_hold("zw2", 64'h8000_0004, 32'h2222_2222);
        drv(0, 0, 0, 0, 0); tick();
        chk_req("zw3", 64'h8000_0008);

        // wait states: three idle cycles, then data_ok
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0); tick();
            chk_req("ws", 64'h8000_0008);
        end
        drv(1, 32'h3333_3333, 0, 0, 0); tick();
        chk_hold("ws_done", 64'h8000_0008, 32'h3333_3333);

        // downstream hold; stray data_ok in HOLD must be ignored
        for (int i = 0; i < 4; i++) begin
            drv(1, 32'h0BAD_0BAD, 1, 0, 0); tick();
            chk_hold("hld", 64'h8000_0008, 32'h3333_3333);
        end
        drv(0, 0, 0, 0, 0); tick();
        chk_req("hld_rel", 64'h8000_000C);

        // redirect while request outstanding
        drv(0, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 1, 64'h8000_0100); tick();
        chk_req("fl0", 64'h8000_000C);
        drv(0, 0, 0, 0, 0); tick();
        chk_req("fl1", 64'h8000_000C);
        drv(1, 32'hDEAD_BEEF, 0, 0, 0); tick();
        chk_req("fl_done", 64'h8000_0100);

        // redirect with data_ok in the same REQ cycle
        drv(1, 32'hDEAD_BEEF, 0, 1, 64'h200); tick();
        chk_req("rd_same", 64'h200);

        // double redirect in FLUSH: last pend wins
        drv(0, 0, 0, 1, 64'h400); tick();
        chk_req("dr0", 64'h200);
        drv(0, 0, 0, 1, 64'h300); tick();
        chk_req("dr1", 64'h200);
        drv(1, 32'hDEAD_BEEF, 0, 0, 0); tick();
        chk_req("dr_done", 64'h300);

        // unaligned redirect target via pend_pc
        drv(0, 0, 0, 1, 64'h8000_0102); tick();
        drv(1, 32'hDEAD_BEEF, 0, 0, 0); tick();
        chk_req("algn", 64'h8000_0100);

        // FLUSH drain with a redirect in the same cycle beats pend_pc
        drv(0, 0, 0, 1, 64'h600); tick();
        drv(1, 32'hDEAD_BEEF, 0, 1, 64'h707); tick();
        chk_req("fl_rd", 64'h704);

        // reset mid-FLUSH
        drv(0, 0, 0, 1, 64'h900); tick();
        chk_req("pre_rst", 64'h704);
        reset = 1'b1;
        drv(0, 0, 0, 0, 0); tick();
        reset = 1'b0;
        chk_req("mid_rst", 64'h8000_0000);

        // redirect over hold discards the buffered instruction
        drv(1, 32'hAAAA_AAAA, 0, 0, 0); tick();
        chk_hold("rh0", 64'h8000_0000, 32'hAAAA_AAAA);
        drv(0, 0, 1, 1, 64'h1000); tick();
        chk_req("rh1", 64'h1000);

        // 64-bit PC wrap on consume
        drv(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC); tick();
        chk_req("wr0", 64'hFFFF_FFFF_FFFF_FFFC);
        drv(1, 32'h5555_5555, 0, 0, 0); tick();
        chk_hold("wr1", 64'hFFFF_FFFF_FFFF_FFFC, 32'h5555_5555);
        drv(0, 0, 0, 0, 0); tick();
        chk_req("wr2", 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
